mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 11, memory word-address width.
REQ-002 Parameter DATA_W, default 32, memory data width.
REQ-003 Parameter STARVE_LIMIT, default 4, consecutive fetch denials before fetch is forced to win (legal range 1..15).
REQ-004 Port list SHALL be:
- clk  in  1  single clock; all state changes on posedge clk.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  instruction-fetch read request.
- if_adrs  in  ADDR_W  fetch address (pc count).
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  DATA_W  fetch read data.
- stall_fetch  out  1  fetch requested but not granted; freezes PC/decode.
- dm_req  in  1  data-memory request from MEM stage.
- dm_we  in  1  1 = store, 0 = load.
- dm_adrs  in  ADDR_W  load/store address.
- dm_wdata  in  DATA_W  store data.
- dm_gnt  out  1  data request accepted this cycle.
- dm_rvalid  out  1  load data valid.
- dm_rdata  out  DATA_W  load data.
- read_mem  out  1  memory read enable.
- write_mem  out  1  memory write enable.
- mem_radrs  out  ADDR_W  memory read address.
- mem_wadrs  out  ADDR_W  memory write address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after read_mem.

Function
REQ-005 At most one memory access (read or write) SHALL be issued per cycle; read_mem and write_mem never both 1.
REQ-006 Grants SHALL be combinational in the request cycle; a requester holds req/address/data stable until it sees gnt.
REQ-007 Only dm_req: dm_gnt=1; if only if_req: if_gnt=1; neither: no access, both gnt 0.
REQ-008 Both requesting and starve_cnt < STARVE_LIMIT: dm wins, starve_cnt increments.
REQ-009 Both requesting and starve_cnt == STARVE_LIMIT: fetch wins, starve_cnt clears.
REQ-010 starve_cnt SHALL clear whenever if_gnt=1 or if_req=0; never exceeds STARVE_LIMIT.
REQ-011 Granted read: read_mem=1, mem_radrs = granted address; granted store: write_mem=1, mem_wadrs=dm_adrs, mem_wdata=dm_wdata.
REQ-012 Idle memory outputs: read_mem=write_mem=0, addresses and mem_wdata hold 0.
REQ-013 Registered FSM tracks last-cycle issue: IDLE, IF_RD, DM_RD, DM_WR; next state = access granted this cycle (IDLE if none).
REQ-014 State IF_RD: if_rvalid=1, if_rdata=mem_rdata; DM_RD: dm_rvalid=1, dm_rdata=mem_rdata; otherwise rvalid 0 and rdata 0.
REQ-015 Read latency SHALL be exactly 1 cycle from gnt to rvalid; back-to-back grants allowed every cycle, no bubbles.
REQ-016 Store SHALL produce no rvalid; a load granted the cycle after a store to the same address returns the stored data.
REQ-017 stall_fetch = if_req & ~if_gnt, combinational.

Reset
REQ-018 While reset=1: all gnt, rvalid, read_mem, write_mem, stall_fetch = 0; addresses/data outputs = 0; requests ignored.
REQ-019 Synchronous reset SHALL set state=IDLE, starve_cnt=0; a read issued the cycle before reset produces no rvalid.
REQ-020 First cycle after reset deasserts arbitration follows REQ-007..009 with starve_cnt=0.

Structure
REQ-021 Shared package cpu_pkg SHALL hold ADDR_W/DATA_W defaults, opcode constants (LOAD..NOOP) and the arbiter state encoding.
REQ-022 Starvation counter SHALL be one sub-module, arb_starve_cnt (inc/clr/saturate, at_limit output); rest in mem_arbiter.

Verification
REQ-023 if_req=1, if_adrs=0x005, memory[5]=0xDEADBEEF -> if_gnt same cycle, next cycle if_rvalid=1, if_rdata=0xDEADBEEF.
REQ-024 dm store adrs 0x010 data 0x12345678, then dm load 0x010 next cycle -> write_mem then read_mem, dm_rvalid with 0x12345678, no if_rvalid.
REQ-025 if_req and dm_req held 1 continuously, STARVE_LIMIT=4 -> grant pattern dm,dm,dm,dm,if repeating; stall_fetch=1 on dm cycles.
REQ-026 Alternating fetch/load every cycle -> one access per cycle, rvalid routed to correct port each cycle, never both rvalid.
REQ-027 reset asserted the cycle after an if read grant -> no if_rvalid, all outputs 0, starve_cnt=0 after reset.
REQ-028 Random req/we/adrs 10k cycles vs. reference model -> no dual access, latency 1, starvation bound STARVE_LIMIT never exceeded.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: bus width defaults, opcode classes
// and the memory arbiter state encoding.
package cpu_pkg;

  localparam int ADDR_W_DFLT = 11;
  localparam int DATA_W_DFLT = 32;

  localparam logic [2:0] LOAD   = 3'd0;
  localparam logic [2:0] STORE  = 3'd1;
  localparam logic [2:0] ALU    = 3'd2;
  localparam logic [2:0] BRANCH = 3'd3;
  localparam logic [2:0] JUMP   = 3'd4;
  localparam logic [2:0] NOOP   = 3'd5;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_IF_RD = 2'd1;
  localparam logic [1:0] S_DM_RD = 2'd2;
  localparam logic [1:0] S_DM_WR = 2'd3;

endpackage

// File: rtl/arb_starve_cnt.sv
// Counts consecutive fetch denials; saturates at LIMIT
// so the arbiter can force fetch to win.
module arb_starve_cnt
  import cpu_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [3:0] LIM = 4'(LIMIT);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr)
      cnt <= '0;
    else if (inc && (cnt < LIM))
      cnt <= cnt + 4'd1;
  end

  assign at_limit = (cnt == LIM);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and
// the MEM stage; data side wins unless fetch is starving.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DFLT,
  parameter int DATA_W       = DATA_W_DFLT,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_adrs,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              stall_fetch,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_adrs,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              read_mem,
  output logic              write_mem,
  output logic [ADDR_W-1:0] mem_radrs,
  output logic [ADDR_W-1:0] mem_wadrs,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic       at_limit;
  logic       dm_rd;
  logic       dm_wr;
  logic [1:0] state;
  logic [1:0] nxt;

  arb_starve_cnt #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .reset   (reset),
    .inc     (dm_gnt & if_req),
    .clr     (if_gnt | ~if_req),
    .at_limit(at_limit)
  );

  assign if_gnt = ~reset & if_req
                & (~dm_req | at_limit);
  assign dm_gnt = ~reset & dm_req
                & (~if_req | ~at_limit);

  assign dm_rd = dm_gnt & ~dm_we;
  assign dm_wr = dm_gnt & dm_we;

  assign stall_fetch = ~reset & if_req & ~if_gnt;

  assign read_mem  = if_gnt | dm_rd;
  assign write_mem = dm_wr;

  always_comb begin
    mem_radrs = '0;
    mem_wadrs = '0;
    mem_wdata = '0;
    if (if_gnt)
      mem_radrs = if_adrs;
    else if (dm_rd)
      mem_radrs = dm_adrs;
    if (dm_wr) begin
      mem_wadrs = dm_adrs;
      mem_wdata = dm_wdata;
    end
  end

  always_comb begin
    nxt = S_IDLE;
    unique case (1'b1)
      if_gnt:  nxt = S_IF_RD;
      dm_rd:   nxt = S_DM_RD;
      dm_wr:   nxt = S_DM_WR;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= nxt;
  end

  // Gate with reset so a read issued just before reset is dropped.
  assign if_rvalid = ~reset & (state == S_IF_RD);
  assign dm_rvalid = ~reset & (state == S_DM_RD);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed check of mem_arbiter against a
// cycle-level behavioural model with its own memory image.
module tb_mem_arbiter;

  localparam int AW    = 11;
  localparam int DW    = 32;
  localparam int LIMIT = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_adrs;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          stall_fetch;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_adrs;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;
  logic          read_mem;
  logic          write_mem;
  logic [AW-1:0] mem_radrs;
  logic [AW-1:0] mem_wadrs;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  mem_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .if_adrs    (if_adrs),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .stall_fetch(stall_fetch),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_adrs    (dm_adrs),
    .dm_wdata   (dm_wdata),
    .dm_gnt     (dm_gnt),
    .dm_rvalid  (dm_rvalid),
    .dm_rdata   (dm_rdata),
    .read_mem   (read_mem),
    .write_mem  (write_mem),
    .mem_radrs  (mem_radrs),
    .mem_wadrs  (mem_wadrs),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [DW-1:0] init_word(int i);
    if (i == 5)
      return 32'hDEAD_BEEF;
    return 32'hA5A5_0000 ^ (i * 32'h0101_0101);
  endfunction

  // Environment memory seen by the DUT
  logic [DW-1:0] mem [DEPTH];
  // Model's independent memory image
  logic [DW-1:0] mref [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]  = init_word(i);
      mref[i] = init_word(i);
    end
    mem_rdata = '0;
  end

  always @(posedge clk) begin
    if (write_mem)
      mem[mem_wadrs] <= mem_wdata;
    if (read_mem)
      mem_rdata <= mem[mem_radrs];
  end

  task automatic chk(string name,
                     logic [63:0] act,
                     logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%h required=%h",
               name, $time, act, exp);
    end
  endtask

  // Behavioural model state
  int            mstarve = 0;
  int            nstall  = 0;
  int            pend    = 0;
  logic [DW-1:0] pdata   = '0;

  always @(negedge clk) begin : model
    logic          e_if;
    logic          e_dm;
    logic          e_rd;
    logic          e_wr;
    logic [AW-1:0] e_ra;
    if (reset) begin
      chk("rst_if_gnt", 64'(if_gnt), 0);
      chk("rst_dm_gnt", 64'(dm_gnt), 0);
      chk("rst_stall", 64'(stall_fetch), 0);
      chk("rst_if_rv", 64'(if_rvalid), 0);
      chk("rst_dm_rv", 64'(dm_rvalid), 0);
      chk("rst_if_rd", 64'(if_rdata), 0);
      chk("rst_dm_rd", 64'(dm_rdata), 0);
      chk("rst_rmem", 64'(read_mem), 0);
      chk("rst_wmem", 64'(write_mem), 0);
      chk("rst_radrs", 64'(mem_radrs), 0);
      chk("rst_wadrs", 64'(mem_wadrs), 0);
      chk("rst_wdata", 64'(mem_wdata), 0);
      mstarve = 0;
      nstall  = 0;
      pend    = 0;
    end else begin
      e_if = if_req && (!dm_req || mstarve == LIMIT);
      e_dm = dm_req && !e_if;
      e_rd = e_if || (e_dm && !dm_we);
      e_wr = e_dm && dm_we;
      e_ra = e_if ? if_adrs
           : (e_dm && !dm_we) ? dm_adrs : '0;
      chk("if_gnt", 64'(if_gnt), 64'(e_if));
      chk("dm_gnt", 64'(dm_gnt), 64'(e_dm));
      chk("stall", 64'(stall_fetch),
          64'(if_req && !e_if));
      chk("read_mem", 64'(read_mem), 64'(e_rd));
      chk("write_mem", 64'(write_mem), 64'(e_wr));
      chk("one_access",
          64'(read_mem && write_mem), 0);
      chk("radrs", 64'(mem_radrs), 64'(e_ra));
      chk("wadrs", 64'(mem_wadrs),
          64'(e_wr ? dm_adrs : '0));
      chk("wdata", 64'(mem_wdata),
          64'(e_wr ? dm_wdata : '0));
      chk("if_rvalid", 64'(if_rvalid),
          64'(pend == 1));
      chk("if_rdata", 64'(if_rdata),
          64'(pend == 1 ? pdata : '0));
      chk("dm_rvalid", 64'(dm_rvalid),
          64'(pend == 2));
      chk("dm_rdata", 64'(dm_rdata),
          64'(pend == 2 ? pdata : '0));
      if (if_req && !if_gnt)
        nstall++;
      else
        nstall = 0;
      chk("starve_bound", 64'(nstall <= LIMIT), 1);
      pend = 0;
      if (e_wr)
        mref[dm_adrs] = dm_wdata;
      if (e_if) begin
        pend  = 1;
        pdata = mref[if_adrs];
      end else if (e_dm && !dm_we) begin
        pend  = 2;
        pdata = mref[dm_adrs];
      end
      if (e_if || !if_req)
        mstarve = 0;
      else if (e_dm)
        mstarve++;
    end
  end

  task automatic drive(logic          rst,
                       logic          ir,
                       logic [AW-1:0] ia,
                       logic          dr,
                       logic          dw,
                       logic [AW-1:0] da,
                       logic [DW-1:0] dd);
    @(posedge clk);
    #1;
    reset    = rst;
    if_req   = ir;
    if_adrs  = ia;
    dm_req   = dr;
    dm_we    = dw;
    dm_adrs  = da;
    dm_wdata = dd;
    @(negedge clk);
  endtask

  initial begin
    logic          ir;
    logic          dr;
    logic          dw;
    logic [AW-1:0] ia;
    logic [AW-1:0] da;
    logic [DW-1:0] dd;
    reset    = 1'b1;
    if_req   = 1'b0;
    if_adrs  = '0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_adrs  = '0;
    dm_wdata = '0;
    repeat (3) drive(1, 1, 11'h003, 1, 0, 11'h004, 0);

    // Fetch read of word 5
    drive(0, 1, 11'h005, 0, 0, 0, 0);
    chk("d_if_gnt", 64'(if_gnt), 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("d_if_rv", 64'(if_rvalid), 1);
    chk("d_if_rdata", 64'(if_rdata), 64'hDEADBEEF);

    // Store then load same address
    drive(0, 0, 0, 1, 1, 11'h010, 32'h1234_5678);
    chk("d_st_wmem", 64'(write_mem), 1);
    chk("d_st_rmem", 64'(read_mem), 0);
    drive(0, 0, 0, 1, 0, 11'h010, 0);
    chk("d_ld_rmem", 64'(read_mem), 1);
    chk("d_st_nodv", 64'(dm_rvalid), 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("d_ld_rv", 64'(dm_rvalid), 1);
    chk("d_ld_data", 64'(dm_rdata), 64'h12345678);
    chk("d_ld_noif", 64'(if_rvalid), 0);

    // Continuous contention: dm x4 then fetch
    for (int k = 0; k < 10; k++) begin
      drive(0, 1, 11'h007, 1, 0, 11'h003, 0);
      chk("d_pat_if", 64'(if_gnt),
          64'(k % 5 == 4));
      chk("d_pat_dm", 64'(dm_gnt),
          64'(k % 5 != 4));
      chk("d_pat_stall", 64'(stall_fetch),
          64'(k % 5 != 4));
    end

    // Alternating fetch / load
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0)
        drive(0, 1, 11'(k), 0, 0, 0, 0);
      else
        drive(0, 0, 0, 1, 0, 11'(k + 16), 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("d_alt_dmrv", 64'(dm_rvalid), 1);

    // Reset right after a fetch grant
    drive(0, 1, 11'h009, 0, 0, 0, 0);
    chk("d_pre_gnt", 64'(if_gnt), 1);
    drive(1, 1, 11'h009, 0, 0, 0, 0);
    chk("d_rst_norv", 64'(if_rvalid), 0);
    chk("d_rst_nord", 64'(read_mem), 0);
    drive(0, 1, 11'h009, 1, 0, 11'h004, 0);
    chk("d_post_dm", 64'(dm_gnt), 1);
    chk("d_post_norv", 64'(if_rvalid), 0);

    // Random traffic with hold-until-grant requesters
    ir = 0; dr = 0; dw = 0;
    ia = '0; da = '0; dd = '0;
    for (int c = 0; c < 10000; c++) begin
      if (!(if_req && !if_gnt)) begin
        ir = ($urandom_range(0, 3) != 0);
        ia = AW'($urandom_range(0, 31));
      end
      if (!(dm_req && !dm_gnt)) begin
        dr = ($urandom_range(0, 2) != 0);
        dw = $urandom_range(0, 1) != 0;
        da = AW'($urandom_range(0, 31));
        dd = $urandom;
      end
      drive(0, ir, ia, dr, dw, da, dd);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
